// File: rtl/sp_ram_be_pipe.sv
// -----------------------------------------------------------------------------
// sp_ram_be_pipe
//   Single-port synchronous RAM with per-byte write enables, a 1- or 2-cycle
//   registered read path, selectable read-during-write return data, and a
//   sequential clear engine. The engine runs after reset when CLEAR_ON_RESET=1
//   and whenever i_clr is requested while idle. Accesses to addr >= SIZE are
//   dropped and flagged on o_addrErr.
//
// Ports
//   i_clk        clock, all logic on posedge
//   i_rst        asynchronous active-high reset
//   i_cs         access request
//   i_we         1 = write, 0 = read (qualified by i_cs)
//   i_be         byte write enables, i_be[k] -> i_data[8k+7:8k]
//   i_addr       word address
//   i_data       write data
//   i_clr        request to clear every word to 0
//   o_dataOut    returned word, holds between returns
//   o_dataValid  one-cycle pulse aligned with a new o_dataOut
//   o_busy       high while the clear engine runs; accesses are ignored
//   o_addrErr    one-cycle pulse after an accepted access with addr >= SIZE
//
// FSM
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | accepting accesses; i_clr starts a clear (and wins over i_cs)
//   ST_CLEAR | zeroing word r_cnt each cycle; back to ST_IDLE after SIZE-1
// -----------------------------------------------------------------------------
module sp_ram_be_pipe #(
    parameter int ADDRWIDTH      = 4,
    parameter int DATAWIDTH      = 8,
    parameter int SIZE           = 16,
    parameter int RD_LATENCY     = 1,
    parameter int WRITE_MODE     = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_cs,
    input  logic                   i_we,
    input  logic [DATAWIDTH/8-1:0] i_be,
    input  logic [ADDRWIDTH-1:0]   i_addr,
    input  logic [DATAWIDTH-1:0]   i_data,
    input  logic                   i_clr,
    output logic [DATAWIDTH-1:0]   o_dataOut,
    output logic                   o_dataValid,
    output logic                   o_busy,
    output logic                   o_addrErr
);

    localparam int NBYTES = DATAWIDTH / 8;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;
    localparam logic [0:0] ST_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    // One extra bit so SIZE == 2**ADDRWIDTH still compares correctly.
    localparam logic [ADDRWIDTH:0]   SIZE_EXT  = (ADDRWIDTH+1)'(SIZE);
    localparam logic [ADDRWIDTH-1:0] LAST_WORD = ADDRWIDTH'(SIZE - 1);

    logic [DATAWIDTH-1:0] r_mem [SIZE];

    logic [0:0]           r_state;
    logic [ADDRWIDTH-1:0] r_cnt;

    logic                 r_s1_vld;
    logic [DATAWIDTH-1:0] r_s1_data;
    logic                 r_err;

    logic                 w_accept;
    logic                 w_in_range;
    logic                 w_hit;
    logic [DATAWIDTH-1:0] w_old_word;
    logic [DATAWIDTH-1:0] w_merged_word;
    logic [DATAWIDTH-1:0] w_ret_word;

    assign w_in_range = ({1'b0, i_addr} < SIZE_EXT);
    assign w_accept   = (r_state == ST_IDLE) && i_cs && !i_clr;
    assign w_hit      = w_accept && w_in_range;

    // Array read ahead of the edge gives read-first data for free; a read on
    // the following cycle sees the updated word.
    assign w_old_word = r_mem[i_addr];

    always_comb begin
        w_merged_word = w_old_word;
        for (int k = 0; k < NBYTES; k++) begin
            if (i_be[k]) begin
                w_merged_word[8*k +: 8] = i_data[8*k +: 8];
            end
        end
    end

    assign w_ret_word = (i_we && (WRITE_MODE != 0)) ? w_merged_word : w_old_word;

    // Storage is deliberately not reset; the clear engine owns initialisation.
    // Writes are held off while i_rst is high so CLEAR_ON_RESET=0 cannot
    // corrupt words during reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (r_state == ST_CLEAR) begin
                r_mem[r_cnt] <= '0;
            end else if (w_hit && i_we) begin
                for (int k = 0; k < NBYTES; k++) begin
                    if (i_be[k]) begin
                        r_mem[i_addr][8*k +: 8] <= i_data[8*k +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_RESET;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    // clr during a clear is ignored: no restart.
                    if (r_cnt == LAST_WORD) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + ADDRWIDTH'(1);
                    end
                end
                default: begin
                    if (i_clr) begin
                        r_state <= ST_CLEAR;
                        r_cnt   <= '0;
                    end
                end
            endcase
        end
    end

    // First read stage: data is captured at the accept edge, so reads already
    // in flight when a clear starts still return pre-clear contents.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_data <= '0;
            r_err     <= 1'b0;
        end else begin
            r_s1_vld <= w_hit;
            r_err    <= w_accept && !w_in_range;
            if (w_hit) begin
                r_s1_data <= w_ret_word;
            end
        end
    end

    // Any RD_LATENCY other than 2 builds the single-stage path.
    if (RD_LATENCY == 2) begin : g_lat2
        logic                 r_out_vld;
        logic [DATAWIDTH-1:0] r_out_data;

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_out_vld  <= 1'b0;
                r_out_data <= '0;
            end else begin
                r_out_vld <= r_s1_vld;
                if (r_s1_vld) begin
                    r_out_data <= r_s1_data;
                end
            end
        end

        assign o_dataValid = r_out_vld;
        assign o_dataOut   = r_out_data;
    end else begin : g_lat1
        assign o_dataValid = r_s1_vld;
        assign o_dataOut   = r_s1_data;
    end

    assign o_busy    = (r_state == ST_CLEAR);
    assign o_addrErr = r_err;

endmodule

// File: tb/tb_sp_ram_be_pipe.sv
// -----------------------------------------------------------------------------
// tb_sp_ram_be_pipe
//   Two configurations driven by one shared stimulus stream:
//     cfg0: 8-bit words, SIZE=16, read latency 1, read-first returns
//     cfg1: 16-bit words, SIZE=12, read latency 2, write-first returns
//   Each configuration has a transaction-level model (array + return queue)
//   compared against the DUT every cycle, plus literal spot checks.
// -----------------------------------------------------------------------------
module tb_sp_ram_be_pipe;

    logic        clk;
    logic        rst;
    logic        cs;
    logic        we;
    logic [1:0]  be;
    logic [3:0]  addr;
    logic [15:0] data;
    logic        clr;

    int n_cmp  = 0;
    int n_fail = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int DW  = (g == 0) ? 8  : 16;
        localparam int SZ  = (g == 0) ? 16 : 12;
        localparam int LAT = (g == 0) ? 1  : 2;
        localparam int WM  = (g == 0) ? 0  : 1;
        localparam int NB  = DW / 8;

        logic [DW-1:0] dout;
        logic          dv;
        logic          busy;
        logic          err;

        sp_ram_be_pipe #(
            .ADDRWIDTH(4), .DATAWIDTH(DW), .SIZE(SZ),
            .RD_LATENCY(LAT), .WRITE_MODE(WM), .CLEAR_ON_RESET(1)
        ) u_dut (
            .i_clk(clk), .i_rst(rst), .i_cs(cs), .i_we(we),
            .i_be(be[NB-1:0]), .i_addr(addr), .i_data(data[DW-1:0]), .i_clr(clr),
            .o_dataOut(dout), .o_dataValid(dv), .o_busy(busy), .o_addrErr(err)
        );

        // Model: words still to clear, contents, and a queue of (due edge, word).
        logic [DW-1:0] m_mem [SZ];
        int            m_clear_left;
        int            m_cyc;
        int            q_due [$];
        logic [DW-1:0] q_val [$];
        logic [DW-1:0] m_old;
        logic [DW-1:0] m_new;
        logic [DW-1:0] e_dout;
        logic          e_dv;
        logic          e_err;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                m_clear_left = SZ;
                m_cyc        = 0;
                q_due.delete();
                q_val.delete();
                e_dout = '0;
                e_dv   = 1'b0;
                e_err  = 1'b0;
            end else begin
                m_cyc++;
                e_dv  = 1'b0;
                e_err = 1'b0;
                if (m_clear_left > 0) begin
                    m_mem[SZ - m_clear_left] = '0;
                    m_clear_left--;
                end else if (clr) begin
                    m_clear_left = SZ;
                end else if (cs) begin
                    if (int'(addr) >= SZ) begin
                        e_err = 1'b1;
                    end else begin
                        m_old = m_mem[addr];
                        m_new = m_old;
                        for (int k = 0; k < NB; k++)
                            if (be[k]) m_new[8*k +: 8] = data[8*k +: 8];
                        if (we) m_mem[addr] = m_new;
                        q_due.push_back(m_cyc + LAT - 1);
                        q_val.push_back((we && WM == 1) ? m_new : m_old);
                    end
                end
                if (q_due.size() > 0 && q_due[0] == m_cyc) begin
                    e_dv   = 1'b1;
                    e_dout = q_val[0];
                    void'(q_due.pop_front());
                    void'(q_val.pop_front());
                end
            end
        end

        always @(negedge clk) begin
            chk($sformatf("cfg%0d dataValid", g), 32'(dv),   32'(e_dv));
            chk($sformatf("cfg%0d dataOut", g),   32'(dout), 32'(e_dout));
            chk($sformatf("cfg%0d addrErr", g),   32'(err),  32'(e_err));
            chk($sformatf("cfg%0d busy", g),      32'(busy), 32'(m_clear_left > 0));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            cs = 1'b0; we = 1'b0; be = 2'b00; clr = 1'b0;
        end
    endtask

    task automatic acc(input bit w, input logic [3:0] a, input logic [15:0] d, input logic [1:0] b);
        @(negedge clk);
        cs = 1'b1; we = w; addr = a; data = d; be = b; clr = 1'b0;
    endtask

    // Counts negedge samples with busy high until it falls again (bounded).
    task automatic measure_busy(input string tag, input bit hold_cs, input bit poke_clr);
        int c0 = 0;
        int c1 = 0;
        bit d0 = 1'b0;
        bit d1 = 1'b0;
        for (int i = 0; i < 40 && !(d0 && d1); i++) begin
            #1;
            if (g_cfg[0].busy) c0++; else if (c0 > 0) d0 = 1'b1;
            if (g_cfg[1].busy) c1++; else if (c1 > 0) d1 = 1'b1;
            @(negedge clk);
            cs  = hold_cs;
            we  = 1'b0;
            clr = poke_clr && (i == 4);
        end
        chk({tag, " busy cycles cfg0"}, 32'(c0), 32'd16);
        chk({tag, " busy cycles cfg1"}, 32'(c1), 32'd12);
    endtask

    logic [15:0] rnd [16];

    initial begin
        rst = 1'b1; cs = 1'b0; we = 1'b0; be = 2'b00; addr = '0; data = '0; clr = 1'b0;
        repeat (3) @(negedge clk);

        // Clear after reset with cs held high; then all words read 0.
        rst = 1'b0; cs = 1'b1; we = 1'b0; addr = 4'd0;
        measure_busy("reset", 1'b1, 1'b0);
        cs = 1'b0;
        for (int a = 0; a < 16; a++) acc(1'b0, 4'(a), 16'h0, 2'b00);
        idle(4);
        chk("post-clear dout cfg0", 32'(g_cfg[0].dout), 32'h0);
        chk("post-clear dout cfg1", 32'(g_cfg[1].dout), 32'h0);

        // Random fill and read back, back-to-back.
        for (int a = 0; a < 16; a++) begin
            rnd[a] = 16'($urandom);
            acc(1'b1, 4'(a), rnd[a], 2'b11);
        end
        for (int a = 0; a < 16; a++) acc(1'b0, 4'(a), 16'h0, 2'b00);
        idle(4);
        chk("fill last dout cfg0", 32'(g_cfg[0].dout), 32'(rnd[15][7:0]));
        chk("fill last dout cfg1", 32'(g_cfg[1].dout), 32'(rnd[11]));

        // Latency pins: cfg0 one cycle, cfg1 two cycles.
        acc(1'b0, 4'd4, 16'h0, 2'b00);
        @(negedge clk); cs = 1'b0;
        chk("lat1 valid cfg0", 32'(g_cfg[0].dv), 32'd1);
        chk("lat1 data cfg0",  32'(g_cfg[0].dout), 32'(rnd[4][7:0]));
        chk("lat1 novalid cfg1", 32'(g_cfg[1].dv), 32'd0);
        @(negedge clk);
        chk("lat2 valid cfg1", 32'(g_cfg[1].dv), 32'd1);
        chk("lat2 data cfg1",  32'(g_cfg[1].dout), 32'(rnd[4]));
        chk("lat2 novalid cfg0", 32'(g_cfg[0].dv), 32'd0);

        // Byte-enable merge.
        acc(1'b1, 4'd3, 16'hABCD, 2'b11);
        acc(1'b1, 4'd3, 16'h1234, 2'b01);
        acc(1'b0, 4'd3, 16'h0000, 2'b00);
        idle(3);
        chk("merge dout cfg0", 32'(g_cfg[0].dout), 32'h34);
        chk("merge dout cfg1", 32'(g_cfg[1].dout), 32'hAB34);

        // Read-during-write return data.
        acc(1'b1, 4'd5, 16'h0011, 2'b11);
        idle(1);
        acc(1'b1, 4'd5, 16'h0022, 2'b11);
        idle(3);
        chk("rdw old cfg0", 32'(g_cfg[0].dout), 32'h11);
        chk("rdw new cfg1", 32'(g_cfg[1].dout), 32'h0022);
        acc(1'b0, 4'd5, 16'h0, 2'b00);
        idle(3);
        chk("rdw reread cfg0", 32'(g_cfg[0].dout), 32'h22);
        chk("rdw reread cfg1", 32'(g_cfg[1].dout), 32'h0022);

        // Out of range for cfg1 (SIZE=12), in range for cfg0.
        acc(1'b1, 4'd13, 16'h00EE, 2'b11);
        @(negedge clk); cs = 1'b0; we = 1'b0;
        chk("oor wr err cfg1",   32'(g_cfg[1].err), 32'd1);
        chk("oor wr valid cfg1", 32'(g_cfg[1].dv),  32'd0);
        chk("inr wr err cfg0",   32'(g_cfg[0].err), 32'd0);
        idle(3);
        chk("oor wr dout cfg1", 32'(g_cfg[1].dout), 32'h0022);
        chk("inr wr dout cfg0", 32'(g_cfg[0].dout), 32'(rnd[13][7:0]));
        acc(1'b0, 4'd13, 16'h0, 2'b00);
        @(negedge clk); cs = 1'b0;
        chk("oor rd err cfg1", 32'(g_cfg[1].err), 32'd1);
        idle(3);
        chk("oor rd dout cfg1", 32'(g_cfg[1].dout), 32'h0022);
        chk("inr rd dout cfg0", 32'(g_cfg[0].dout), 32'hEE);

        // clr together with a read: read dropped, clear runs; clr mid-clear ignored.
        @(negedge clk);
        cs = 1'b1; we = 1'b0; addr = 4'd2; clr = 1'b1;
        measure_busy("clr", 1'b0, 1'b1);
        for (int a = 0; a < 16; a++) acc(1'b0, 4'(a), 16'h0, 2'b00);
        idle(4);
        chk("clr dout cfg0", 32'(g_cfg[0].dout), 32'h0);
        chk("clr dout cfg1", 32'(g_cfg[1].dout), 32'h0);

        // Reset in the middle of a clear.
        acc(1'b1, 4'd1, 16'h5A5A, 2'b11);
        acc(1'b0, 4'd1, 16'h0, 2'b00);
        idle(3);
        chk("pre-rst dout cfg0", 32'(g_cfg[0].dout), 32'h5A);
        chk("pre-rst dout cfg1", 32'(g_cfg[1].dout), 32'h5A5A);
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst dout cfg0", 32'(g_cfg[0].dout), 32'h0);
        chk("rst dout cfg1", 32'(g_cfg[1].dout), 32'h0);
        chk("rst busy cfg0", 32'(g_cfg[0].busy), 32'd1);
        chk("rst busy cfg1", 32'(g_cfg[1].busy), 32'd1);
        @(negedge clk); rst = 1'b0;
        measure_busy("rerun", 1'b0, 1'b0);
        for (int a = 0; a < 16; a++) acc(1'b0, 4'(a), 16'h0, 2'b00);
        idle(4);
        chk("rerun dout cfg0", 32'(g_cfg[0].dout), 32'h0);
        chk("rerun dout cfg1", 32'(g_cfg[1].dout), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
